id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage pipeline. It feeds ArithmeticLogicUnit (A, B, Op, usigned) in EX.
- Captures decoded operands and control from ID each cycle.
- Applies EX/MEM and MEM/WB forwarding to the registered operands, then selects immediate/shamt into the ALU inputs.
- Detects load-use hazards and handles hold, flush and bubble insertion.

---
 rtl/id_ex_stage_pkg.sv | 44 ++++
 rtl/id_ex_stage_fwd_mux.sv | 37 +++
 rtl/id_ex_stage.sv | 186 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared widths, reset PC, ALU op codes, bubble control and hit helper.
package id_ex_stage_pkg;

  localparam int unsigned PKG_DATA_W   = 32;
  localparam int unsigned PKG_REG_AW   = 5;
  localparam int unsigned SHAMT_W      = 5;
  localparam int unsigned ALU_OP_W     = 4;
  localparam logic [31:0] PKG_RESET_PC = 32'h0000_3000;

  // ALU Op encodings, grouped add/sub, bit ops, lui, shifts, compares.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_LUI  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_SLT  = 4'd10,
    ALU_SLTU = 4'd11
  } alu_op_e;

  // Control bits that travel with the instruction into MEM/WB.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  // A bubble must never write a register or touch memory.
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(3'b000);

  // True when a writer targeting dst produces the value for source register src.
  // Register $0 is hard-wired to zero, so it never matches.
  function automatic logic dst_hits(input logic                  wr,
                                    input logic [PKG_REG_AW-1:0] dst,
                                    input logic [PKG_REG_AW-1:0] src);
    return wr && (dst != {PKG_REG_AW{1'b0}}) && (dst == src);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// id_ex_stage_fwd_mux: 3:1 priority operand forward, EX/MEM over MEM/WB over own data.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = PKG_DATA_W,
  parameter int unsigned REG_AW = PKG_REG_AW
) (
  input  logic [REG_AW-1:0] i_src_addr,
  input  logic [DATA_W-1:0] i_src_data,
  input  logic              i_exm_reg_write,
  input  logic [REG_AW-1:0] i_exm_rd,
  input  logic [DATA_W-1:0] i_exm_result,
  input  logic              i_mwb_reg_write,
  input  logic [REG_AW-1:0] i_mwb_rd,
  input  logic [DATA_W-1:0] i_mwb_result,
  output logic [DATA_W-1:0] o_data
);

  logic w_exm_hit;
  logic w_mwb_hit;

  assign w_exm_hit = dst_hits(i_exm_reg_write, i_exm_rd, i_src_addr);
  assign w_mwb_hit = dst_hits(i_mwb_reg_write, i_mwb_rd, i_src_addr);

  // Youngest producer wins: EX/MEM result is newer than MEM/WB result.
  always_comb begin
    o_data = i_src_data;
    if (w_exm_hit) begin
      o_data = i_exm_result;
    end else if (w_mwb_hit) begin
      o_data = i_mwb_result;
    end else begin
      o_data = i_src_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, ALU input
// selection, load-use detection and hold/flush/bubble handling.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = PKG_DATA_W,
  parameter int unsigned REG_AW   = PKG_REG_AW,
  parameter logic [31:0] RESET_PC = PKG_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [31:0]         id_pc,
  input  logic [REG_AW-1:0]   id_rs_addr,
  input  logic [REG_AW-1:0]   id_rt_addr,
  input  logic [REG_AW-1:0]   id_rd_addr,
  input  logic [DATA_W-1:0]   id_rs_data,
  input  logic [DATA_W-1:0]   id_rt_data,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [SHAMT_W-1:0]  id_shamt,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_usigned,
  input  logic                id_src_imm,
  input  logic                id_src_shamt,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                exm_reg_write,
  input  logic [REG_AW-1:0]   exm_rd,
  input  logic [DATA_W-1:0]   exm_result,
  input  logic                mwb_reg_write,
  input  logic [REG_AW-1:0]   mwb_rd,
  input  logic [DATA_W-1:0]   mwb_result,
  input  logic                hold,
  input  logic                flush,
  output logic                load_use,
  output logic                ex_valid,
  output logic [31:0]         ex_pc,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_usigned,
  output logic [DATA_W-1:0]   ex_store_data,
  output logic [REG_AW-1:0]   ex_rd,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write
);

  logic                r_valid;
  logic [31:0]         r_pc;
  logic [REG_AW-1:0]   r_rs_addr;
  logic [REG_AW-1:0]   r_rt_addr;
  logic [REG_AW-1:0]   r_rd;
  logic [DATA_W-1:0]   r_rs_data;
  logic [DATA_W-1:0]   r_rt_data;
  logic [DATA_W-1:0]   r_imm;
  logic [SHAMT_W-1:0]  r_shamt;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic                r_usigned;
  logic                r_src_imm;
  logic                r_src_shamt;
  ctrl_t               r_ctrl;

  logic [DATA_W-1:0]   w_fwd_rs;
  logic [DATA_W-1:0]   w_fwd_rt;
  logic                w_load_use;
  logic                w_bubble;

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .i_src_addr      (r_rs_addr),
    .i_src_data      (r_rs_data),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_rd        (exm_rd),
    .i_exm_result    (exm_result),
    .i_mwb_reg_write (mwb_reg_write),
    .i_mwb_rd        (mwb_rd),
    .i_mwb_result    (mwb_result),
    .o_data          (w_fwd_rs)
  );

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .i_src_addr      (r_rt_addr),
    .i_src_data      (r_rt_data),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_rd        (exm_rd),
    .i_exm_result    (exm_result),
    .i_mwb_reg_write (mwb_reg_write),
    .i_mwb_rd        (mwb_rd),
    .i_mwb_result    (mwb_result),
    .o_data          (w_fwd_rt)
  );

  // A load in EX whose target is read by ID cannot forward in time; conservative
  // on rt (stores stall too). A flush kills both instructions, so no stall.
  assign w_load_use = !flush && id_valid && r_valid &&
                      (dst_hits(r_ctrl.mem_read, r_rd, id_rs_addr) ||
                       dst_hits(r_ctrl.mem_read, r_rd, id_rt_addr));

  // Flush always bubbles; a load-use stall bubbles only when not held.
  assign w_bubble = flush || (!hold && w_load_use);

  // Pipeline register update, priority flush > hold > load-use > capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= RESET_PC;
      r_rs_addr   <= {REG_AW{1'b0}};
      r_rt_addr   <= {REG_AW{1'b0}};
      r_rd        <= {REG_AW{1'b0}};
      r_rs_data   <= {DATA_W{1'b0}};
      r_rt_data   <= {DATA_W{1'b0}};
      r_imm       <= {DATA_W{1'b0}};
      r_shamt     <= {SHAMT_W{1'b0}};
      r_alu_op    <= {ALU_OP_W{1'b0}};
      r_usigned   <= 1'b0;
      r_src_imm   <= 1'b0;
      r_src_shamt <= 1'b0;
      r_ctrl      <= CTRL_BUBBLE;
    end else if (w_bubble) begin
      r_valid     <= 1'b0;
      r_pc        <= 32'h0000_0000;
      r_rs_addr   <= {REG_AW{1'b0}};
      r_rt_addr   <= {REG_AW{1'b0}};
      r_rd        <= {REG_AW{1'b0}};
      r_rs_data   <= {DATA_W{1'b0}};
      r_rt_data   <= {DATA_W{1'b0}};
      r_imm       <= {DATA_W{1'b0}};
      r_shamt     <= {SHAMT_W{1'b0}};
      r_alu_op    <= {ALU_OP_W{1'b0}};
      r_usigned   <= 1'b0;
      r_src_imm   <= 1'b0;
      r_src_shamt <= 1'b0;
      r_ctrl      <= CTRL_BUBBLE;
    end else if (hold) begin
      // Latch forwarded operands so they survive their producer retiring.
      r_rs_data   <= w_fwd_rs;
      r_rt_data   <= w_fwd_rt;
    end else begin
      r_valid            <= id_valid;
      r_pc               <= id_pc;
      r_rs_addr          <= id_rs_addr;
      r_rt_addr          <= id_rt_addr;
      r_rd               <= id_rd_addr;
      r_rs_data          <= id_rs_data;
      r_rt_data          <= id_rt_data;
      r_imm              <= id_imm;
      r_shamt            <= id_shamt;
      r_alu_op           <= id_alu_op;
      r_usigned          <= id_usigned;
      r_src_imm          <= id_src_imm;
      r_src_shamt        <= id_src_shamt;
      r_ctrl.reg_write   <= id_valid && id_reg_write;
      r_ctrl.mem_read    <= id_valid && id_mem_read;
      r_ctrl.mem_write   <= id_valid && id_mem_write;
    end
  end

  // ALU operand select; shifts take the amount on A and the value on B.
  always_comb begin
    alu_a = w_fwd_rs;
    alu_b = w_fwd_rt;
    if (r_src_shamt) begin
      alu_a = {{(DATA_W-SHAMT_W){1'b0}}, r_shamt};
    end else begin
      alu_a = w_fwd_rs;
    end
    if (r_src_imm) begin
      alu_b = r_imm;
    end else begin
      alu_b = w_fwd_rt;
    end
  end

  assign load_use      = w_load_use;
  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign alu_op        = r_alu_op;
  assign alu_usigned   = r_usigned;
  assign ex_store_data = w_fwd_rt;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table, hand sequences and randomized model checks.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_alu_op;
  logic        id_usigned, id_src_imm, id_src_shamt;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_result;
  logic        hold, flush;
  logic        load_use, ex_valid;
  logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_op;
  logic        alu_usigned;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int n_total = 0;
  int n_pass  = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_usigned(id_usigned),
    .id_src_imm(id_src_imm), .id_src_shamt(id_src_shamt),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .hold(hold), .flush(flush), .load_use(load_use), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_usigned(alu_usigned), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in EX.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val, imm;
    logic [4:0]  shamt;
    logic [3:0]  op;
    logic        us, s_imm, s_sh, rw, mr, mw;
  } ex_t;
  ex_t m;

  typedef struct {
    logic [4:0]  rs, rt;
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  shamt;
    logic        s_imm, s_sh;
    logic        exm_w; logic [4:0] exm_a; logic [31:0] exm_v;
    logic        mwb_w; logic [4:0] mwb_a; logic [31:0] mwb_v;
    logic [31:0] ea, eb, esd;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Value seen for source register a: newest in-flight writer, else own copy; $0 never.
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] own);
    if (exm_reg_write && exm_rd != 5'd0 && exm_rd == a) return exm_result;
    if (mwb_reg_write && mwb_rd != 5'd0 && mwb_rd == a) return mwb_result;
    return own;
  endfunction

  function automatic logic exp_load_use();
    return !flush && id_valid && m.valid && m.mr && m.rd != 5'd0 &&
           (m.rd == id_rs_addr || m.rd == id_rt_addr);
  endfunction

  task automatic model_reset();
    m = '0;
    m.pc = 32'h0000_3000;
  endtask

  // Advance one clock: compute the model's next EX content, then cross the edge.
  task automatic tick();
    ex_t n;
    n = m;
    if (flush) begin
      n = '0;
    end else if (hold) begin
      n.rs_val = fwd(m.rs, m.rs_val);
      n.rt_val = fwd(m.rt, m.rt_val);
    end else if (exp_load_use()) begin
      n = '0;
    end else begin
      n.valid = id_valid; n.pc = id_pc; n.rs = id_rs_addr; n.rt = id_rt_addr;
      n.rd = id_rd_addr; n.rs_val = id_rs_data; n.rt_val = id_rt_data;
      n.imm = id_imm; n.shamt = id_shamt; n.op = id_alu_op; n.us = id_usigned;
      n.s_imm = id_src_imm; n.s_sh = id_src_shamt;
      n.rw = id_valid & id_reg_write; n.mr = id_valid & id_mem_read;
      n.mw = id_valid & id_mem_write;
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic check_model();
    chk("load_use", {31'd0, load_use}, {31'd0, exp_load_use()});
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
    chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m.rw});
    chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m.mr});
    chk("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, m.mw});
    if (m.valid) begin
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
      chk("alu_op", {28'd0, alu_op}, {28'd0, m.op});
      chk("alu_usigned", {31'd0, alu_usigned}, {31'd0, m.us});
      chk("alu_a", alu_a, m.s_sh ? {27'd0, m.shamt} : fwd(m.rs, m.rs_val));
      chk("alu_b", alu_b, m.s_imm ? m.imm : fwd(m.rt, m.rt_val));
      chk("store_data", ex_store_data, fwd(m.rt, m.rt_val));
    end
  endtask

  task automatic id_set(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_pc = pc; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 32'd0; id_shamt = 5'd0;
    id_alu_op = 4'd0; id_usigned = 1'b0; id_src_imm = 1'b0; id_src_shamt = 1'b0;
  endtask

  task automatic bypass_off();
    exm_reg_write = 1'b0; exm_rd = 5'd0; exm_result = 32'd0;
    mwb_reg_write = 1'b0; mwb_rd = 5'd0; mwb_result = 32'd0;
  endtask

  logic freeze;

  initial begin
    // rs, rt, rs_d, rt_d, imm, shamt, s_imm, s_sh, exm(w,a,v), mwb(w,a,v), exp a, b, store
    vecs[0] = '{5'd8, 5'd1, 32'h5,  32'h6, 32'h0,    5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h11,        1'b1, 5'd8, 32'h22,        32'h11, 32'h6,    32'h6};
    vecs[1] = '{5'd8, 5'd1, 32'h5,  32'h6, 32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 32'h11,        1'b1, 5'd8, 32'h22,        32'h22, 32'h6,    32'h6};
    vecs[2] = '{5'd0, 5'd0, 32'h0,  32'h0, 32'h0,    5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hEEEE_EEEE, 32'h0,  32'h0,    32'h0};
    vecs[3] = '{5'd2, 5'd3, 32'hAA, 32'h7, 32'h1234, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 32'h55,        1'b0, 5'd0, 32'h0,         32'h4,  32'h1234, 32'h55};
    vecs[4] = '{5'd2, 5'd3, 32'hAA, 32'h7, 32'h1234, 5'd4, 1'b0, 1'b0, 1'b1, 5'd4, 32'h55,        1'b1, 5'd3, 32'h99,        32'hAA, 32'h99,   32'h99};
    vecs[5] = '{5'd6, 5'd6, 32'h1,  32'h1, 32'h0,    5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h10,        1'b1, 5'd6, 32'h20,        32'h10, 32'h10,   32'h10};
    vecs[6] = '{5'd7, 5'd1, 32'h77, 32'h2, 32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h44,        1'b1, 5'd7, 32'h33,        32'h33, 32'h2,    32'h2};

    // Reset state
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    id_set(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bypass_off();
    model_reset();
    #3;
    chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst ex_pc", ex_pc, 32'h0000_3000);
    chk("rst reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst ex_rd", {27'd0, ex_rd}, 32'd0);
    chk("rst load_use", {31'd0, load_use}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Forwarding / operand select table
    for (int i = 0; i < 7; i++) begin
      id_set(1'b1, 32'h1000 + 32'(i * 4), vecs[i].rs, vecs[i].rt, 5'd1, 1'b1, 1'b0, 1'b0);
      id_rs_data = vecs[i].rs_d; id_rt_data = vecs[i].rt_d; id_imm = vecs[i].imm;
      id_shamt = vecs[i].shamt; id_src_imm = vecs[i].s_imm; id_src_shamt = vecs[i].s_sh;
      bypass_off();
      tick();
      exm_reg_write = vecs[i].exm_w; exm_rd = vecs[i].exm_a; exm_result = vecs[i].exm_v;
      mwb_reg_write = vecs[i].mwb_w; mwb_rd = vecs[i].mwb_a; mwb_result = vecs[i].mwb_v;
      #1;
      chk($sformatf("vec%0d alu_a", i), alu_a, vecs[i].ea);
      chk($sformatf("vec%0d alu_b", i), alu_b, vecs[i].eb);
      chk($sformatf("vec%0d store", i), ex_store_data, vecs[i].esd);
    end
    bypass_off();

    // Load-use stall: load $9 in EX, ID reads rt=$9
    id_set(1'b1, 32'h100, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 32'h104, 5'd3, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu raised", {31'd0, load_use}, 32'd1);
    tick();
    chk("lu bubble valid", {31'd0, ex_valid}, 32'd0);
    chk("lu bubble rw", {31'd0, ex_reg_write}, 32'd0);
    chk("lu cleared", {31'd0, load_use}, 32'd0);
    tick();
    chk("lu replay valid", {31'd0, ex_valid}, 32'd1);
    chk("lu replay pc", ex_pc, 32'h104);
    chk("lu replay rd", {27'd0, ex_rd}, 32'd10);

    // Hold while the MEM/WB producer retires
    id_set(1'b1, 32'h200, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    id_valid = 1'b0;
    mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_result = 32'hABCD;
    #1;
    chk("hold fwd", alu_a, 32'hABCD);
    hold = 1'b1;
    tick();
    mwb_reg_write = 1'b0;
    #1;
    chk("hold c1 alu_a", alu_a, 32'hABCD);
    chk("hold c1 pc", ex_pc, 32'h200);
    tick();
    chk("hold c2 alu_a", alu_a, 32'hABCD);
    hold = 1'b0;
    bypass_off();

    // Flush with hold and a load-use condition present
    id_set(1'b1, 32'h300, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    id_set(1'b1, 32'h304, 5'd9, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1);
    flush = 1'b1; hold = 1'b1;
    #1;
    chk("flush lu", {31'd0, load_use}, 32'd0);
    tick();
    chk("flush valid", {31'd0, ex_valid}, 32'd0);
    chk("flush rw", {31'd0, ex_reg_write}, 32'd0);
    chk("flush mr", {31'd0, ex_mem_read}, 32'd0);
    chk("flush mw", {31'd0, ex_mem_write}, 32'd0);
    flush = 1'b0; hold = 1'b0;

    // Asynchronous reset mid-stream
    id_set(1'b1, 32'h400, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre-rst valid", {31'd0, ex_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst valid", {31'd0, ex_valid}, 32'd0);
    chk("async rst pc", ex_pc, 32'h0000_3000);
    chk("async rst rw", {31'd0, ex_reg_write}, 32'd0);
    chk("async rst lu", {31'd0, load_use}, 32'd0);
    model_reset();
    #1;
    rst = 1'b0;

    // Randomized traffic against the model
    freeze = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!freeze) begin
        id_set($urandom_range(0, 7) != 0, $urandom, 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 1'($urandom));
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_shamt = 5'($urandom); id_alu_op = 4'($urandom); id_usigned = 1'($urandom);
        id_src_imm = 1'($urandom); id_src_shamt = 1'($urandom);
      end
      exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
      mwb_reg_write = 1'($urandom); mwb_rd = 5'($urandom_range(0, 3)); mwb_result = $urandom;
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      check_model();
      freeze = !flush && (hold || exp_load_use());
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
